// File: rtl/mbinit_sb_pkg.sv
// Shared MBINIT sideband definitions: message codes and the TX arbiter state encoding.
package mbinit_sb_pkg;

  localparam logic [3:0] SB_MSG_START_REQ          = 4'b0001;
  localparam logic [3:0] SB_MSG_START_RESP         = 4'b0010;
  localparam logic [3:0] SB_MSG_END_REQ            = 4'b0011;
  localparam logic [3:0] SB_MSG_END_RESP           = 4'b0100;
  localparam logic [3:0] SB_MSG_APPLY_DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] SB_MSG_APPLY_DEGRADE_RESP = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SEND      = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_RELEASE   = 2'b11
  } sb_arb_state_t;

endpackage

// File: rtl/sb_req_slot.sv
// One-deep holding register for a single sideband requester, with overflow detect.
module sb_req_slot (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_msg,
  input  logic [1:0] req_msginfo,
  input  logic       clear,
  output logic       pend,
  output logic       pend_next,
  output logic [3:0] msg,
  output logic [1:0] info,
  output logic       overflow_hit
);

  logic       pend_reg;
  logic [3:0] msg_reg;
  logic [1:0] info_reg;
  logic       load;

  // A full slot (including one being released this cycle) never accepts a new request.
  assign load         = req_valid & ~pend_reg;
  assign overflow_hit = req_valid & pend_reg;
  assign pend_next    = load | (pend_reg & ~clear);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= 1'b0;
      msg_reg  <= 4'b0000;
      info_reg <= 2'b00;
    end else begin
      pend_reg <= pend_next;
      if (load) begin
        msg_reg  <= req_msg;
        info_reg <= req_msginfo;
      end
    end
  end

  assign pend = pend_reg;
  assign msg  = msg_reg;
  assign info = info_reg;

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX path between the REPAIRMB initiator and responder.
// Optional watchdog on the serializer completion is enabled with SB_ARB_TIMEOUT_EN.
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [1:0] i_req_valid,
  input  logic [7:0] i_req_msg,
  input  logic [3:0] i_req_msginfo,
  output logic       o_sb_valid,
  output logic [3:0] o_sb_msg,
  output logic [1:0] o_sb_msginfo,
  input  logic       i_sb_done,
  output logic       o_Busy_SideBand,
  output logic       o_falling_edge_busy,
  output logic [1:0] o_req_done,
  output logic       o_overflow,
  output logic       o_timeout
);

  sb_arb_state_t state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_grant_reg;
  logic          finish_ok;

  logic [1:0] pend;
  logic [1:0] pend_next;
  logic [1:0] ovf_hit;
  logic [1:0] slot_clear;
  logic [3:0] slot_msg  [2];
  logic [1:0] slot_info [2];

  logic       sb_valid_reg;
  logic [3:0] sb_msg_reg;
  logic [1:0] sb_info_reg;
  logic [1:0] req_done_reg;
  logic       overflow_reg;
  logic       busy_reg, busy_next;
  logic       fall_reg;

  assign slot_clear = (state_reg == ST_RELEASE) ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      sb_req_slot u_slot (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .req_valid    (i_req_valid[gi]),
        .req_msg      (i_req_msg[4*gi +: 4]),
        .req_msginfo  (i_req_msginfo[2*gi +: 2]),
        .clear        (slot_clear[gi]),
        .pend         (pend[gi]),
        .pend_next    (pend_next[gi]),
        .msg          (slot_msg[gi]),
        .info         (slot_info[gi]),
        .overflow_hit (ovf_hit[gi])
      );
    end
  endgenerate

`ifdef SB_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] wait_cnt_reg;
  logic       timeout_hit;
  logic       timeout_reg;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 10'd0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == ST_WAIT_DONE) ? wait_cnt_reg + 10'd1 : 10'd0;
      timeout_reg  <= timeout_reg | timeout_hit;
    end
  end

  assign o_timeout = timeout_reg;
`else
  logic [9:0] timeout_unused;
  assign timeout_unused = 10'(TIMEOUT_CYCLES);
  assign o_timeout      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    finish_ok  = 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|pend) begin
          state_next = ST_SEND;
          grant_next = (&pend) ? ~last_grant_reg : pend[1];
        end
      end
      ST_SEND: state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_sb_done) begin
          state_next = ST_RELEASE;
          finish_ok  = 1'b1;
        end
`ifdef SB_ARB_TIMEOUT_EN
        else if (wait_cnt_reg == TO_LIMIT) begin
          state_next  = ST_RELEASE;
          timeout_hit = 1'b1;
        end
`endif
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign busy_next = (|pend_next) | (state_next != ST_IDLE);

  // Launch fields are registered off the IDLE->SEND decision so they line up with the SEND cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_reg   <= 1'b0;
      sb_msg_reg     <= 4'b0000;
      sb_info_reg    <= 2'b00;
      req_done_reg   <= 2'b00;
      last_grant_reg <= 1'b1;
      overflow_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      fall_reg       <= 1'b0;
    end else begin
      sb_valid_reg <= (state_next == ST_SEND);
      sb_msg_reg   <= (state_next == ST_SEND) ? slot_msg[grant_next]  : 4'b0000;
      sb_info_reg  <= (state_next == ST_SEND) ? slot_info[grant_next] : 2'b00;
      req_done_reg <= finish_ok ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;
      if (state_reg == ST_RELEASE) begin
        last_grant_reg <= grant_reg;
      end
      overflow_reg <= overflow_reg | (|ovf_hit);
      busy_reg     <= busy_next;
      fall_reg     <= busy_reg & ~busy_next;
    end
  end

  assign o_sb_valid          = sb_valid_reg;
  assign o_sb_msg            = sb_msg_reg;
  assign o_sb_msginfo        = sb_info_reg;
  assign o_req_done          = req_done_reg;
  assign o_overflow          = overflow_reg;
  assign o_Busy_SideBand     = busy_reg;
  assign o_falling_edge_busy = fall_reg;

endmodule
